// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight destination writes, produces forwarding selects, load-use and multi-cycle-mul stalls.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / mul_stall_cnt statistics outputs.
module pipe_hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_STAGE = 2,
    parameter int MUL_LAT    = 4
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               id_valid,
    input  logic                               id_flush,
    input  logic                               id_wreg,
    input  logic                               id_m2reg,
    input  logic                               id_mul,
    input  logic [REG_AW-1:0]                  id_rn,
    input  logic [REG_AW-1:0]                  rs,
    input  logic [REG_AW-1:0]                  rt,
    input  logic                               rs_used,
    input  logic                               rt_used,
    output logic                               stall,
    output logic                               ex_hold,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_a,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_b,
    output logic [$clog2(MUL_LAT+1)-1:0]       ex_busy_cnt
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                        stall_cnt,
    output logic [31:0]                        mul_stall_cnt
`endif
);

    localparam int SW = $clog2(FWD_DEPTH + 1);
    localparam int CW = $clog2(MUL_LAT + 1);

    logic [FWD_DEPTH:1] v_r;
    logic [FWD_DEPTH:1] ld_r;
    logic [REG_AW-1:0]  rn_r [1:FWD_DEPTH];
    logic               s1_mul_r;
    logic [CW-1:0]      cnt_r;

    logic               busy_s;
    logic               lu_stall_s;
    logic               stall_s;
    logic               issue_s;
    logic [SW:0]        hit_a_s;
    logic [SW:0]        hit_b_s;

    // Returns {load_use, select} for one operand; the downward scan leaves the youngest match.
    function automatic logic [SW:0] lookup(input logic [REG_AW-1:0] r, input logic used);
        logic [SW-1:0] sel;
        logic          lu;
        sel = '0;
        lu  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (used && (r != '0) && v_r[k] && (rn_r[k] == r)) begin
                sel = SW'(k);
                lu  = ld_r[k] && (k < LOAD_STAGE);
            end else begin
                sel = sel;
                lu  = lu;
            end
        end
        // A mul still computing in EXE has no result yet; stall covers this cycle.
        if ((sel == SW'(1)) && s1_mul_r && busy_s) begin
            sel = '0;
        end else begin
            sel = sel;
        end
        return {lu, sel};
    endfunction

    // Operand lookup and stall/issue decode.
    always_comb begin
        busy_s     = (cnt_r != '0);
        hit_a_s    = lookup(rs, rs_used);
        hit_b_s    = lookup(rt, rt_used);
        lu_stall_s = hit_a_s[SW] | hit_b_s[SW];
        stall_s    = lu_stall_s | busy_s;
        issue_s    = id_valid & ~id_flush & ~stall_s;
    end

    assign stall       = stall_s;
    assign ex_hold     = busy_s;
    assign fwd_a       = hit_a_s[SW-1:0];
    assign fwd_b       = hit_b_s[SW-1:0];
    assign ex_busy_cnt = cnt_r;

    // Tag pipeline and multiply occupancy counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_r      <= '0;
            ld_r     <= '0;
            s1_mul_r <= 1'b0;
            cnt_r    <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                rn_r[k] <= '0;
            end
        end else if (busy_s) begin
            v_r[2]  <= 1'b0;
            ld_r[2] <= 1'b0;
            for (int k = 3; k <= FWD_DEPTH; k++) begin
                v_r[k]  <= v_r[k-1];
                ld_r[k] <= ld_r[k-1];
                rn_r[k] <= rn_r[k-1];
            end
            cnt_r <= cnt_r - CW'(1);
        end else begin
            v_r[1]   <= issue_s & id_wreg;
            ld_r[1]  <= issue_s & id_m2reg;
            s1_mul_r <= issue_s & id_mul;
            rn_r[1]  <= id_rn;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                v_r[k]  <= v_r[k-1];
                ld_r[k] <= ld_r[k-1];
                rn_r[k] <= rn_r[k-1];
            end
            if (issue_s && id_mul) begin
                cnt_r <= CW'(MUL_LAT - 1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] mul_stall_cnt_r;

    // Saturating stall statistics.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r     <= 32'd0;
            mul_stall_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (busy_s && (mul_stall_cnt_r != 32'hFFFF_FFFF)) begin
                mul_stall_cnt_r <= mul_stall_cnt_r + 32'd1;
            end else begin
                mul_stall_cnt_r <= mul_stall_cnt_r;
            end
        end
    end

    assign stall_cnt     = stall_cnt_r;
    assign mul_stall_cnt = mul_stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Table-driven bench for pipe_hazard_scoreboard (default parameters), plus an asynchronous-reset-during-mul sequence.
module tb_pipe_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       resetn;
    logic       id_valid, id_flush, id_wreg, id_m2reg, id_mul;
    logic [4:0] id_rn, rs, rt;
    logic       rs_used, rt_used;
    logic       stall, ex_hold;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] ex_busy_cnt;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, mul_stall_cnt;
`endif

    pipe_hazard_scoreboard dut (
        .clock(clock), .resetn(resetn),
        .id_valid(id_valid), .id_flush(id_flush), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_mul(id_mul), .id_rn(id_rn),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
        .stall(stall), .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_busy_cnt(ex_busy_cnt)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .mul_stall_cnt(mul_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic v, fl, w, ld, mu;
        int   rn, rs, rt;
        logic ru, tu;
        logic st, eh;
        int   fa, fb, cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_stall_sum = 0;
    int   exp_hold_sum  = 0;

    function automatic void row(input logic v, fl, w, ld, mu, input int rn, rs_i, rt_i,
                                input logic ru, tu, st, eh, input int fa, fb, cnt);
        vec_t r;
        r.v = v; r.fl = fl; r.w = w; r.ld = ld; r.mu = mu;
        r.rn = rn; r.rs = rs_i; r.rt = rt_i; r.ru = ru; r.tu = tu;
        r.st = st; r.eh = eh; r.fa = fa; r.fb = fb; r.cnt = cnt;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v, input int idx);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, fl, w, ld, mu, input int rn, rs_i, rt_i, input logic ru, tu);
        id_valid = v; id_flush = fl; id_wreg = w; id_m2reg = ld; id_mul = mu;
        id_rn = 5'(rn); rs = 5'(rs_i); rt = 5'(rt_i); rs_used = ru; rt_used = tu;
    endtask

    task automatic chk_all(input int st, eh, fa, fb, cnt, input int idx);
        chk("stall", int'(stall), st, idx);
        chk("ex_hold", int'(ex_hold), eh, idx);
        chk("fwd_a", int'(fwd_a), fa, idx);
        chk("fwd_b", int'(fwd_b), fb, idx);
        chk("ex_busy_cnt", int'(ex_busy_cnt), cnt, idx);
    endtask

    initial begin
        //   v fl w ld mu  rn rs rt  ru tu  st eh fa fb cnt
        row(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,0);  // reset state
        row(1,0,1,0,0,  3, 1, 2, 1,1, 0,0,0,0,0);  // add r3
        row(1,0,1,0,0,  4, 3, 3, 1,1, 0,0,1,1,0);  // sub r4,r3,r3 from EXE
        row(1,0,1,0,0,  8, 3, 0, 1,1, 0,0,2,0,0);  // r3 from MEM, rt=r0
        row(1,0,0,0,0,  0, 3, 4, 1,1, 0,0,3,2,0);  // r3 from WB, r4 from MEM
        row(0,0,0,0,0,  0, 8, 4, 1,0, 0,0,2,0,0);  // rt unused
        row(1,0,1,1,0,  5, 8, 0, 1,0, 0,0,3,0,0);  // lw r5
        row(1,0,1,0,0,  9, 5, 5, 1,0, 1,0,1,0,0);  // load-use stall
        row(1,0,1,0,0,  9, 5, 5, 1,0, 0,0,2,0,0);  // released, from MEM
        row(1,0,1,0,1,  6, 9, 0, 1,0, 0,0,1,0,0);  // mul r6
        row(0,0,0,0,0,  0, 6, 6, 0,0, 1,1,0,0,3);
        row(0,0,0,0,0,  0, 6, 6, 0,0, 1,1,0,0,2);
        row(0,0,0,0,0,  0, 6, 6, 0,0, 1,1,0,0,1);
        row(1,0,1,0,0, 11, 6, 6, 1,1, 0,0,1,1,0);  // dependent on mul
        row(1,0,1,0,0,  0, 0,11, 1,0, 0,0,0,0,0);  // writes r0
        row(0,0,0,0,0,  0, 0,11, 1,1, 0,0,0,2,0);  // r0 never forwards
        row(1,0,1,0,0,  7, 6, 0, 1,0, 0,0,0,0,0);  // r6 retired
        row(1,0,1,0,0, 12, 7, 0, 1,0, 0,0,1,0,0);
        row(1,0,1,0,0,  7, 7, 0, 1,0, 0,0,2,0,0);
        row(0,0,0,0,0,  0, 7, 7, 1,1, 0,0,1,1,0);  // r7 in stage 1 and 3
        row(1,1,1,1,0, 13,12, 0, 1,0, 0,0,3,0,0);  // flushed lw r13
        row(1,0,0,0,0,  0,13, 7, 1,1, 0,0,0,3,0);  // no stall after flush
        row(1,0,1,1,0, 14, 0, 0, 0,0, 0,0,0,0,0);  // lw r14
        row(1,1,1,0,0, 15,14, 0, 1,0, 1,0,1,0,0);  // flush + stall
        row(0,0,0,0,0,  0,14, 0, 1,0, 0,0,2,0,0);
        row(0,0,0,0,0,  0,14, 0, 1,0, 0,0,3,0,0);
        row(0,0,0,0,0,  0,14, 0, 1,0, 0,0,0,0,0);  // retired

        resetn = 1'b0;
        drive(0,0,0,0,0, 0,0,0, 0,0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].fl, vecs[i].w, vecs[i].ld, vecs[i].mu,
                  vecs[i].rn, vecs[i].rs, vecs[i].rt, vecs[i].ru, vecs[i].tu);
            #1;
            chk_all(int'(vecs[i].st), int'(vecs[i].eh), vecs[i].fa, vecs[i].fb, vecs[i].cnt, i);
            exp_stall_sum += int'(vecs[i].st);
            exp_hold_sum  += int'(vecs[i].eh);
        end

        // Asynchronous reset while a multiply is in progress.
        @(negedge clock);
        drive(1,0,1,0,0, 15,0,0, 0,0);
        #1;
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", int'(stall_cnt), exp_stall_sum, 100);
        chk("mul_stall_cnt", int'(mul_stall_cnt), exp_hold_sum, 100);
`endif
        @(negedge clock);
        drive(1,0,1,0,1, 6,15,0, 1,0);
        #1;
        chk_all(0, 0, 1, 0, 0, 101);
        @(negedge clock);
        drive(0,0,0,0,0, 0,15,0, 1,0);
        #1;
        chk_all(1, 1, 2, 0, 3, 102);
        @(negedge clock);
        #1;
        chk_all(1, 1, 3, 0, 2, 103);
        #2;
        resetn = 1'b0;
        #1;
        chk_all(0, 0, 0, 0, 0, 104);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt_rst", int'(stall_cnt), 0, 104);
        chk("mul_stall_cnt_rst", int'(mul_stall_cnt), 0, 104);
`endif
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk_all(0, 0, 0, 0, 0, 105);
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
